// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT sequencing controller.
// Holds the controller state encoding, the default transform size, and
// helpers that derive the half-size and twiddle-ROM address width from the
// transform parameters so every file computes them the same way.
package fft_pkg;

    // Default transform size (N = 2^LOG2N)
    localparam int FFT_LOG2N_DEFAULT = 4;
    localparam int FFT_N_DEFAULT     = 1 << FFT_LOG2N_DEFAULT;

    // One butterfly walks RD0 -> RD1 -> LATB -> WR1 -> WR0
    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        LATB,
        WR1,
        WR0,
        DONE
    } fft_state_t;

    // Number of butterflies per stage (N/2)
    function automatic int half_points(input int n);
        return n / 2;
    endfunction

    // Twiddle index k spans 0..N/2-1, so the CROM needs LOG2N-1 address bits
    function automatic int crom_addr_width(input int log2n);
        return log2n - 1;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly index generator for an in-place-style radix-2 DIT FFT.
// Purely combinational; usable by the controller, a host loader or a model.
//
// Ports:
//   s   - stage number, 0..LOG2N-1
//   j   - butterfly number within the stage, 0..N/2-1
//   i0  - address of the upper butterfly input/output
//   i1  - address of the lower butterfly input/output (i0 + 2^s)
//   k   - twiddle index, W_N^k
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N_DEFAULT,
    localparam int SW   = $clog2(LOG2N)
) (
    input  logic [SW-1:0]    s,
    input  logic [LOG2N-2:0] j,
    output logic [LOG2N-1:0] i0,
    output logic [LOG2N-1:0] i1,
    output logic [LOG2N-2:0] k
);

    localparam logic [LOG2N-1:0] ONE   = LOG2N'(1);
    localparam logic [SW-1:0]    TOP_S = SW'(LOG2N - 1);

    logic [LOG2N-1:0] j_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] pos;

    // The group bits of j (above bit s) are moved up one place to open a
    // zero at bit s; that zero is the span bit that separates i0 from i1.
    // The position within the group selects the twiddle, scaled so the
    // final stage uses every CROM entry and stage 0 uses only W^0.
    always_comb begin
        j_ext = {1'b0, j};
        span  = ONE << s;
        mask  = span - ONE;
        pos   = j_ext & mask;
        i0    = ((j_ext & ~mask) << 1) | pos;
        i1    = i0 | span;
        k     = (LOG2N-1)'(pos << (TOP_S - s));
    end

endmodule

// File: rtl/fft_ctrl.sv
// Sequencing controller for the radix-2 DIT FFT datapath.
// Walks LOG2N stages x N/2 butterflies, five cycles per butterfly, and
// ping-pongs data between AMEM and BMEM (even stages read AMEM, odd stages
// read BMEM). All control outputs are registers decoded from the next
// state and next counters, so nothing combinational reaches an output.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - request a transform (honoured only in IDLE)
//   busy, done            - transform in progress / one-cycle completion pulse
//   result_in_b           - final data lives in BMEM (1) or AMEM (0)
//   addr_AMEM, we_AMEM    - AMEM port
//   addr_BMEM, we_BMEM    - BMEM port
//   addr_CROM             - twiddle index
//   sel_mem               - datapath source memory (0 AMEM, 1 BMEM)
//   sel_res               - out_FFT is BF1 (1) or held BF0 in REG_C (0)
//   en_REG_A/B/C          - datapath register enables
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N     = FFT_N_DEFAULT,
    parameter int LOG2N = FFT_LOG2N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             result_in_b,
    output logic [LOG2N-1:0] addr_AMEM,
    output logic             we_AMEM,
    output logic [LOG2N-1:0] addr_BMEM,
    output logic             we_BMEM,
    output logic [LOG2N-2:0] addr_CROM,
    output logic             sel_mem,
    output logic             sel_res,
    output logic             en_REG_A,
    output logic             en_REG_B,
    output logic             en_REG_C
);

    localparam int HALF_N  = half_points(N);
    localparam int CROM_AW = crom_addr_width(LOG2N);
    localparam int SW      = $clog2(LOG2N);

    localparam logic [CROM_AW-1:0] J_LAST = CROM_AW'(HALF_N - 1);
    localparam logic [SW-1:0]      S_LAST = SW'(LOG2N - 1);

    fft_state_t         state, ns;
    logic [SW-1:0]      s, ns_s;
    logic [CROM_AW-1:0] j, ns_j;
    logic [LOG2N-1:0]   nx_i0, nx_i1;
    logic [CROM_AW-1:0] nx_k;
    logic               src_b;

    // Each stage of ping-pong flips the memories, so the final data lands
    // in BMEM exactly when the stage count is odd.
    assign result_in_b = (LOG2N % 2) == 1;

    // Next state and next counters; the counters only move when a
    // butterfly finishes (WR0) and are cleared on the way through DONE.
    always_comb begin
        ns   = state;
        ns_s = s;
        ns_j = j;
        case (state)
            IDLE: if (start) ns = RD0;
            RD0:  ns = RD1;
            RD1:  ns = LATB;
            LATB: ns = WR1;
            WR1:  ns = WR0;
            WR0: begin
                if (j != J_LAST) begin
                    ns_j = j + CROM_AW'(1);
                    ns   = RD0;
                end else if (s != S_LAST) begin
                    ns_j = '0;
                    ns_s = s + SW'(1);
                    ns   = RD0;
                end else begin
                    ns_j = '0;
                    ns_s = '0;
                    ns   = DONE;
                end
            end
            DONE: begin
                ns   = IDLE;
                ns_s = '0;
                ns_j = '0;
            end
            default: begin
                ns   = IDLE;
                ns_s = '0;
                ns_j = '0;
            end
        endcase
    end

    // Addresses for the butterfly being entered, so outputs can be registered
    fft_addr_gen #(
        .LOG2N(LOG2N)
    ) u_addr_gen (
        .s (ns_s),
        .j (ns_j),
        .i0(nx_i0),
        .i1(nx_i1),
        .k (nx_k)
    );

    // Odd stages read BMEM and write AMEM
    assign src_b = ns_s[0];

    // State, counters and every control output. Outputs default to zero
    // each cycle and are then set for the state being entered; the source
    // side gets read addresses, the destination side gets write addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            j         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_AMEM <= '0;
            we_AMEM   <= 1'b0;
            addr_BMEM <= '0;
            we_BMEM   <= 1'b0;
            addr_CROM <= '0;
            sel_mem   <= 1'b0;
            sel_res   <= 1'b0;
            en_REG_A  <= 1'b0;
            en_REG_B  <= 1'b0;
            en_REG_C  <= 1'b0;
        end else begin
            state     <= ns;
            s         <= ns_s;
            j         <= ns_j;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_AMEM <= '0;
            we_AMEM   <= 1'b0;
            addr_BMEM <= '0;
            we_BMEM   <= 1'b0;
            addr_CROM <= '0;
            sel_mem   <= 1'b0;
            sel_res   <= 1'b0;
            en_REG_A  <= 1'b0;
            en_REG_B  <= 1'b0;
            en_REG_C  <= 1'b0;
            case (ns)
                RD0: begin
                    busy    <= 1'b1;
                    sel_mem <= src_b;
                    if (src_b) addr_BMEM <= nx_i0;
                    else       addr_AMEM <= nx_i0;
                end
                RD1: begin
                    busy      <= 1'b1;
                    sel_mem   <= src_b;
                    en_REG_A  <= 1'b1;
                    addr_CROM <= nx_k;
                    if (src_b) addr_BMEM <= nx_i1;
                    else       addr_AMEM <= nx_i1;
                end
                LATB: begin
                    busy      <= 1'b1;
                    sel_mem   <= src_b;
                    en_REG_B  <= 1'b1;
                    addr_CROM <= nx_k;
                end
                WR1: begin
                    busy     <= 1'b1;
                    sel_mem  <= src_b;
                    en_REG_C <= 1'b1;
                    sel_res  <= 1'b1;
                    if (src_b) begin
                        we_AMEM   <= 1'b1;
                        addr_AMEM <= nx_i1;
                    end else begin
                        we_BMEM   <= 1'b1;
                        addr_BMEM <= nx_i1;
                    end
                end
                WR0: begin
                    busy    <= 1'b1;
                    sel_mem <= src_b;
                    if (src_b) begin
                        we_AMEM   <= 1'b1;
                        addr_AMEM <= nx_i0;
                    end else begin
                        we_BMEM   <= 1'b1;
                        addr_BMEM <= nx_i0;
                    end
                end
                DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
- Sequencing controller for the radix-2 DIT FFT datapath: the control end of the datapath's select/enable/memory interface.
- Walks all LOG2N stages × N/2 butterflies.
- Drives the single-port BRAM addresses and write-enables (AMEM/BMEM ping-pong, CROM twiddles), plus the datapath controls sel_mem, sel_res and en_REG_A/B/C.
- Input samples are pre-loaded into AMEM in bit-reversed order. Datapath out_FFT is the write data for both data memories.

Parameters:
- N, 16, FFT points; power of two, ≥4
- LOG2N, 4, log2(N); also the data-memory address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request transform; sampled only in IDLE
- busy  out  1  high from first RD0 through last WR0
- done  out  1  one-cycle pulse after last butterfly write
- result_in_b  out  1  final result location: 1 = BMEM, 0 = AMEM; equals LOG2N[0], static
- addr_AMEM  out  LOG2N  AMEM address (read or write)
- we_AMEM  out  1  AMEM write enable
- addr_BMEM  out  LOG2N  BMEM address
- we_BMEM  out  1  BMEM write enable
- addr_CROM  out  LOG2N-1  twiddle index k; CROM holds W_N^k, k = 0..N/2-1
- sel_mem  out  1  0 = datapath reads AMEM, 1 = BMEM
- sel_res  out  1  1 = out_FFT is BF1 (direct), 0 = out_FFT is REG_C (held BF0)
- en_REG_A  out  1  latch x0
- en_REG_B  out  1  latch x1·W
- en_REG_C  out  1  latch BF0

Behaviour:
- Reset: state IDLE; stage s = 0; butterfly counter j = 0. All outputs 0 except result_in_b (constant).
- Outputs are decoded only from the registered state and counters. There is no combinational path from start.
- Memories have 1-cycle registered read latency.
- States: IDLE, RD0, RD1, LATB, WR1, WR0, DONE.
- Index generation:
  - span = 2^s; group = j >> s; pos = j & (span-1)
  - i0 = group·2·span + pos; i1 = i0 + span
  - k = pos << (LOG2N-1-s)
- Source/destination ping-pong:
  - s even: source = AMEM, destination = BMEM, sel_mem = 0.
  - s odd: source = BMEM, destination = AMEM, sel_mem = 1.
  - sel_mem holds its value through all five states of a butterfly.
- Unused memory address = 0; we = 0 except in WR1/WR0.
- IDLE: start=1 → RD0; busy becomes 1 that cycle.
- RD0: source addr = i0. → RD1.
- RD1: source data = x0; en_REG_A = 1; source addr = i1; addr_CROM = k. → LATB.
- LATB: source data = x1, CROM data = W; en_REG_B = 1; addr_CROM held at k. → WR1.
- WR1: en_REG_C = 1; sel_res = 1; destination we = 1, addr = i1 (writes BF1). → WR0.
- WR0: sel_res = 0; destination we = 1, addr = i0 (writes REG_C = BF0). Then:
  - j < N/2-1: j++ → RD0.
  - j = N/2-1 and s < LOG2N-1: j = 0, s++ → RD0.
  - otherwise → DONE.
- DONE: done = 1, busy = 0; counters cleared. → IDLE unconditionally.
- Cycle count: 5 cycles per butterfly, no overlap. Total busy = 5·(N/2)·LOG2N cycles (160 for N=16).
- start outside IDLE (busy or DONE): ignored, not queued.
- rst mid-operation: immediate return to IDLE, all controls and we = 0, counters cleared. Memory contents are undefined and must be re-loaded by the host.

Decomposition:
- Shared package fft_pkg: state enum, and LOG2N/N-derived localparams (HALF_N, CROM address width).
- One natural sub-module: fft_addr_gen. Combinational (s, j) → (i0, i1, k), reusable by the host loader and the bench model.
- The FSM plus the s/j counters stay in fft_ctrl.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 asynchronously; result_in_b = 0 for N=16.
- start pulse in IDLE (N=16), cycles 1–5 → addr_AMEM = 0, 1; en_REG_A in cycle 2; addr_CROM = 0; en_REG_B in cycle 3; cycle 4: we_BMEM=1, addr_BMEM=1, sel_res=1, en_REG_C=1; cycle 5: addr_BMEM=0, sel_res=0.
- Stage 1, j=1 → sel_mem=1; reads BMEM addr 1 then 3; addr_CROM=4; writes AMEM addr 3 then 1.
- Stage 3, j=5 → reads BMEM 5/13; addr_CROM=5; writes AMEM 13/5. done pulses exactly in cycle 161; busy falls the same cycle.
- start re-pulsed at cycles 50 and 161 → no effect, no re-trigger. rst at cycle 80 then start → sequence restarts at stage 0, j=0 addresses 0/1.
- N=8, LOG2N=3 → done at cycle 61; result_in_b=1; last write to BMEM addr 3; full address trace matches the fft_addr_gen golden model.
